// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default datapath width, forwarding source
// indices and a constant log2 helper used to size select fields.
package cpu_pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  // Smallest r with 2**r >= n; evaluated at elaboration time only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/operand_select_stage_mux_n.sv
// Combinational N-way selector. Encodings at or above NUM_SRC select
// nothing: data is zero and legal is low, so every sel value is defined.
module mux_n #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         data,
  output logic                     legal
);

  always_comb begin
    data  = '0;
    legal = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data  = src_data[i*WIDTH +: WIDTH];
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// Operand select feeding a pipeline register, with stall/flush, valid
// tracking, a sticky illegal-select flag and a saturating forwarding counter.
module operand_select_stage
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = clog2(NUM_SRC),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         fwd_cnt
);

  if (NUM_SRC < 2 || (1 << SEL_W) < NUM_SRC) begin : g_param_check
    $fatal(1, "operand_select_stage: need NUM_SRC>=2 and 2**SEL_W>=NUM_SRC");
  end

  // Slot protocol: in_valid marks a live instruction; a slot is consumed on
  // any edge with stall=0 (flush turns it into a bubble). No ready signal.
  logic [WIDTH-1:0] mux_data;
  logic             mux_legal;
  logic             load;
  logic             err_set;
  logic             cnt_inc;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_mux (
    .src_data(src_data),
    .sel     (sel),
    .data    (mux_data),
    .legal   (mux_legal)
  );

  always_comb begin
    load    = !flush && !stall;
    err_set = load && in_valid && !mux_legal;
    cnt_inc = load && in_valid && mux_legal && (sel != SEL_W'(FWD_RF))
              && (fwd_cnt != {CNT_W{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      // An illegal select keeps the previous operand rather than loading zero.
      if (mux_legal) out_data <= mux_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sel_err <= 1'b0;
    else if (err_set) sel_err <= 1'b1;
    else if (err_clr) sel_err <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fwd_cnt <= '0;
    else if (cnt_inc) fwd_cnt <= fwd_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_operand_select_stage.sv
// Three builds (default, 4-bit counter, 4x64 full-encoding) driven together
// and compared every cycle against a behavioural model, plus literal checks.
module tb_operand_select_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   sel = '0;
  logic         in_valid = 1'b0, stall = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [95:0]  src_a = '0, src_b = '0;
  logic [255:0] src_c = '0;

  logic [31:0] a_data, b_data;
  logic [63:0] c_data;
  logic        a_valid, b_valid, c_valid, a_err, b_err, c_err;
  logic [15:0] a_cnt, c_cnt;
  logic [3:0]  b_cnt;

  operand_select_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .src_data(src_a), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr), .out_data(a_data),
    .out_valid(a_valid), .sel_err(a_err), .fwd_cnt(a_cnt));

  operand_select_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .src_data(src_b), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr), .out_data(b_data),
    .out_valid(b_valid), .sel_err(b_err), .fwd_cnt(b_cnt));

  operand_select_stage #(.WIDTH(64), .NUM_SRC(4), .SEL_W(2), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .src_data(src_c), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr), .out_data(c_data),
    .out_valid(c_valid), .sel_err(c_err), .fwd_cnt(c_cnt));

  logic [63:0] d_data[3];
  logic [63:0] d_cnt[3];
  logic        d_valid[3], d_err[3];
  assign d_data[0] = {32'b0, a_data};
  assign d_data[1] = {32'b0, b_data};
  assign d_data[2] = c_data;
  assign d_cnt[0]  = {48'b0, a_cnt};
  assign d_cnt[1]  = {60'b0, b_cnt};
  assign d_cnt[2]  = {48'b0, c_cnt};
  assign d_valid[0] = a_valid;
  assign d_valid[1] = b_valid;
  assign d_valid[2] = c_valid;
  assign d_err[0] = a_err;
  assign d_err[1] = b_err;
  assign d_err[2] = c_err;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          nsrc[3] = '{3, 3, 4};
  int          cmax[3] = '{65535, 15, 65535};
  logic [63:0] m_data[3] = '{64'd0, 64'd0, 64'd0};
  logic        m_valid[3] = '{1'b0, 1'b0, 1'b0};
  logic        m_err[3] = '{1'b0, 1'b0, 1'b0};
  int          m_cnt[3] = '{0, 0, 0};

  function automatic logic [63:0] src_of(input int k, input int i);
    case (k)
      0:       return {32'b0, src_a[i*32 +: 32]};
      1:       return {32'b0, src_b[i*32 +: 32]};
      default: return src_c[i*64 +: 64];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_data[k] = '0; m_valid[k] = 1'b0; m_err[k] = 1'b0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit raise;
        raise = 1'b0;
        if (flush) begin
          m_data[k] = '0;
          m_valid[k] = 1'b0;
        end else if (!stall) begin
          m_valid[k] = in_valid;
          if (int'(sel) < nsrc[k]) begin
            m_data[k] = src_of(k, int'(sel));
            if (in_valid && sel != 2'd0 && m_cnt[k] < cmax[k]) m_cnt[k]++;
          end else if (in_valid) begin
            raise = 1'b1;
          end
        end
        if (raise) m_err[k] = 1'b1;
        else if (err_clr) m_err[k] = 1'b0;
      end
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        check("data", k, d_data[k], m_data[k]);
        check("valid", k, {63'b0, d_valid[k]}, {63'b0, m_valid[k]});
        check("err", k, {63'b0, d_err[k]}, {63'b0, m_err[k]});
        check("cnt", k, d_cnt[k], 64'(m_cnt[k]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+2; inputs are sampled by the next posedge, and the task
  // returns 2 time units after it with the registered results settled.
  task automatic apply(input logic [1:0] s, input logic v, input logic st = 1'b0,
                       input logic fl = 1'b0, input logic ec = 1'b0);
    sel = s; in_valid = v; stall = st; flush = fl; err_clr = ec;
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset state
    check("rst_data", 0, d_data[0], 64'd0);
    check("rst_valid", 0, {63'b0, a_valid}, 64'd0);
    check("rst_err", 0, {63'b0, a_err}, 64'd0);
    check("rst_cnt", 0, d_cnt[0], 64'd0);

    // Basic select, one-cycle latency
    src_a = {32'hC, 32'hB, 32'hA};
    src_b = src_a;
    src_c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
    for (int s = 0; s < 3; s++) begin
      apply(2'(s), 1'b1);
      check("t1_data", s, d_data[0], {32'b0, exp_q.pop_front()});
      check("t1_valid", s, {63'b0, a_valid}, 64'd1);
    end
    check("t1_cnt", 0, d_cnt[0], 64'd2);

    // Illegal select holds data and raises the sticky flag
    apply(2'd1, 1'b1);
    apply(2'd3, 1'b1);
    check("t2_hold", 0, d_data[0], 64'hB);
    check("t2_err", 0, {63'b0, a_err}, 64'd1);
    check("t2_c_err", 2, {63'b0, c_err}, 64'd0);
    apply(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_clr", 0, {63'b0, a_err}, 64'd0);
    apply(2'd1, 1'b1);
    apply(2'd3, 1'b0);
    check("t2_inv_hold", 0, d_data[0], 64'hB);
    check("t2_inv_err", 0, {63'b0, a_err}, 64'd0);

    // Stall freezes everything; flush beats stall
    apply(2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      src_a = {$urandom, $urandom, $urandom};
      apply(2'(i % 2 + 1), 1'b1, 1'b1);
    end
    check("t3_data", 0, d_data[0], 64'hC);
    check("t3_valid", 0, {63'b0, a_valid}, 64'd1);
    check("t3_cnt", 0, d_cnt[0], 64'd5);
    apply(2'd1, 1'b1, 1'b1, 1'b1);
    check("t3_fl_valid", 0, {63'b0, a_valid}, 64'd0);
    check("t3_fl_data", 0, d_data[0], 64'd0);

    // Counter saturation on the 4-bit build
    reset_pulse();
    src_b = {$urandom, $urandom, $urandom};
    repeat (5) apply(2'd1, 1'b1);
    check("t4_cnt5", 1, d_cnt[1], 64'd5);
    apply(2'd1, 1'b1, 1'b0, 1'b1);
    check("t4_flush", 1, d_cnt[1], 64'd5);
    apply(2'd1, 1'b0);
    check("t4_inv", 1, d_cnt[1], 64'd5);
    repeat (15) apply(2'd1, 1'b1);
    check("t4_sat", 1, d_cnt[1], 64'd15);
    check("t4_wide", 0, d_cnt[0], 64'd20);

    // Asynchronous reset in the middle of a stall
    src_a = {32'h33, 32'h22, 32'h11};
    apply(2'd2, 1'b1);
    apply(2'd3, 1'b1);
    apply(2'd0, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_data", 0, d_data[0], 64'd0);
    check("t5_valid", 0, {63'b0, a_valid}, 64'd0);
    check("t5_err", 0, {63'b0, a_err}, 64'd0);
    check("t5_cnt", 0, d_cnt[0], 64'd0);
    check("t5_c_data", 2, d_data[2], 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply(2'd2, 1'b1);
    check("t5_load", 0, d_data[0], 64'h33);
    check("t5_lvalid", 0, {63'b0, a_valid}, 64'd1);
    check("t5_lcnt", 0, d_cnt[0], 64'd1);

    // Full-encoding build: every select is legal
    for (int s = 0; s < 4; s++) begin
      apply(2'(s), 1'b1);
      check("t6_data", s, d_data[2], src_c[s*64 +: 64]);
      check("t6_err", s, {63'b0, c_err}, 64'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      src_a = {$urandom, $urandom, $urandom};
      src_b = {$urandom, $urandom, $urandom};
      src_c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      apply(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0));
    end
    apply(2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
